// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path: one queued retire result.
// No latency or backpressure of its own; widths match the 32 x 32-bit register file.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_dual_queue.sv
// Circular buffer for retire results: up to 2 pushes and 2 pops per cycle. Count updates one cycle later.
// No backpressure here; the caller may only push into free space and only pop entries that are present.
module wb_dual_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [1:0]                          push_cnt_i,
  input  wb_entry_t                           push0_i,
  input  wb_entry_t                           push1_i,
  input  logic [1:0]                          pop_cnt_i,
  output wb_entry_t                           head0_o,
  output wb_entry_t                           head1_o,
  output logic [$clog2(DEPTH):0]              count_o,
  output logic [DEPTH-1:0]                    valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    rd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    head_d  = head_q + PW'(pop_cnt_i);
    tail_d  = tail_q + PW'(push_cnt_i);
    count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
  end

  always_ff @(posedge clk_i) begin
    if (push_cnt_i != 2'd0) mem_q[tail_q] <= push0_i;
    if (push_cnt_i == 2'd2) mem_q[tail_q + PW'(1)] <= push1_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head0_o = mem_q[head_q];
  assign head1_o = mem_q[head_q + PW'(1)];
  assign count_o = count_q;

  // A slot is live when its distance from head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] ofs;
    assign ofs        = PW'(g) - head_q;
    assign valid_o[g] = {1'b0, ofs} < count_q;
    assign rd_o[g]    = mem_q[g].rd;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CW'(DEPTH));

endmodule

// File: rtl/regfile_writeback_scheduler.sv
// Queues in-order retire results and drains them oldest-first onto the two register-file write ports.
// Entry accepted at edge k is presented after edge k+1 at earliest; InReady drops when fewer than 2 slots are free.
module regfile_writeback_scheduler
  import regfile_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DROP_ZERO = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    InValid0,
  input  logic [REG_ADDR_W-1:0]   InReg0,
  input  logic [REG_DATA_W-1:0]   InData0,
  input  logic                    InValid1,
  input  logic [REG_ADDR_W-1:0]   InReg1,
  input  logic [REG_DATA_W-1:0]   InData1,
  output logic                    InReady,
  input  logic                    ReadReq,
  input  logic [REG_ADDR_W-1:0]   LookupReg,
  output logic                    LookupHit,
  output logic [REG_ADDR_W-1:0]   WriteRegister1,
  output logic [REG_DATA_W-1:0]   WriteData1,
  output logic                    RegWrite1,
  output logic [REG_ADDR_W-1:0]   WriteRegister2,
  output logic [REG_DATA_W-1:0]   WriteData2,
  output logic                    RegWrite2,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t                        slot0, slot1, push0, push1, head0, head1;
  logic                             accept, keep0, keep1;
  logic [1:0]                       push_cnt, pop_cnt;
  logic [CW-1:0]                    count;
  logic [DEPTH-1:0]                 valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd;

  logic                  we1_q, we1_d, we2_q, we2_d;
  logic [REG_ADDR_W-1:0] wr1_q, wr1_d, wr2_q, wr2_d;
  logic [REG_DATA_W-1:0] wd1_q, wd1_d, wd2_q, wd2_d;

  assign slot0 = '{rd: InReg0, data: InData0};
  assign slot1 = '{rd: InReg1, data: InData1};

  // Ready comes only from registered occupancy, never from this cycle's pops.
  assign InReady = count <= CW'(DEPTH - 2);
  assign accept  = InReady && InValid0;
  assign keep0   = accept && !((DROP_ZERO != 0) && (InReg0 == '0));
  assign keep1   = accept && InValid1 && !((DROP_ZERO != 0) && (InReg1 == '0));

  // A discarded slot 0 lets slot 1 take the first free position.
  assign push0    = keep0 ? slot0 : slot1;
  assign push1    = slot1;
  assign push_cnt = {1'b0, keep0} + {1'b0, keep1};

  wb_dual_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .push_cnt_i (push_cnt),
    .push0_i    (push0),
    .push1_i    (push1),
    .pop_cnt_i  (pop_cnt),
    .head0_o    (head0),
    .head1_o    (head1),
    .count_o    (count),
    .valid_o    (valid),
    .rd_o       (rd)
  );

  // Equal destinations collapse onto port 1 with the younger value.
  always_comb begin
    pop_cnt = 2'd0;
    we1_d   = 1'b0;
    we2_d   = 1'b0;
    wr1_d   = wr1_q;
    wd1_d   = wd1_q;
    wr2_d   = wr2_q;
    wd2_d   = wd2_q;
    if (!ReadReq) begin
      if (count >= CW'(2)) begin
        pop_cnt = 2'd2;
        we1_d   = 1'b1;
        if (head0.rd == head1.rd) begin
          wr1_d = head1.rd;
          wd1_d = head1.data;
        end else begin
          wr1_d = head0.rd;
          wd1_d = head0.data;
          we2_d = 1'b1;
          wr2_d = head1.rd;
          wd2_d = head1.data;
        end
      end else if (count == CW'(1)) begin
        pop_cnt = 2'd1;
        we1_d   = 1'b1;
        wr1_d   = head0.rd;
        wd1_d   = head0.data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we1_q <= 1'b0;
      we2_q <= 1'b0;
      wr1_q <= '0;
      wd1_q <= '0;
      wr2_q <= '0;
      wd2_q <= '0;
    end else begin
      we1_q <= we1_d;
      we2_q <= we2_d;
      wr1_q <= wr1_d;
      wd1_q <= wd1_d;
      wr2_q <= wr2_d;
      wd2_q <= wd2_d;
    end
  end

  assign RegWrite1      = we1_q;
  assign WriteRegister1 = wr1_q;
  assign WriteData1     = wd1_q;
  assign RegWrite2      = we2_q;
  assign WriteRegister2 = wr2_q;
  assign WriteData2     = wd2_q;
  assign Count          = count;

  always_comb begin
    LookupHit = (we1_q && (wr1_q == LookupReg)) || (we2_q && (wr2_q == LookupReg));
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (rd[i] == LookupReg)) LookupHit = 1'b1;
    end
  end

  assert property (@(posedge Clk) disable iff (!Reset_n) !(InValid1 && !InValid0));

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Randomised bench for regfile_writeback_scheduler: a queue-level reference model feeds a scoreboard
// that a separate monitor drains once per clock.
module tb_regfile_writeback_scheduler;

  localparam int DEPTH = 8;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        InValid0, InValid1, InReady, ReadReq, LookupHit;
  logic [4:0]  InReg0, InReg1, LookupReg, WriteRegister1, WriteRegister2;
  logic [31:0] InData0, InData1, WriteData1, WriteData2;
  logic        RegWrite1, RegWrite2;
  logic [3:0]  Count;

  always #5 Clk = ~Clk;

  regfile_writeback_scheduler #(.DEPTH(DEPTH), .DROP_ZERO(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .InValid0(InValid0), .InReg0(InReg0), .InData0(InData0),
    .InValid1(InValid1), .InReg1(InReg1), .InData1(InData1),
    .InReady(InReady), .ReadReq(ReadReq),
    .LookupReg(LookupReg), .LookupHit(LookupHit),
    .WriteRegister1(WriteRegister1), .WriteData1(WriteData1), .RegWrite1(RegWrite1),
    .WriteRegister2(WriteRegister2), .WriteData2(WriteData2), .RegWrite2(RegWrite2),
    .Count(Count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          we1;
    logic [4:0]  wr1;
    logic [31:0] wd1;
    bit          we2;
    logic [4:0]  wr2;
    logic [31:0] wd2;
    int          cnt;
    bit          rdy;
  } rec_t;

  ent_t mq[$];      // results waiting in the scheduler, oldest first
  rec_t expq[$];    // expected port state after each clock edge
  int   checks = 0;
  int   errors = 0;
  bit   lw1 = 1'b0, lw2 = 1'b0;
  logic [4:0] lr1 = '0, lr2 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides what the ports must show after the coming edge.
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input bit rr, input logic [4:0] lk, output bit acc);
    rec_t e;
    ent_t x;
    bit   hit;
    int   sz;
    @(negedge Clk);
    InValid0 = v0; InReg0 = a0; InData0 = d0;
    InValid1 = v1; InReg1 = a1; InData1 = d1;
    ReadReq = rr; LookupReg = lk;
    #1;
    hit = (lw1 && lr1 == lk) || (lw2 && lr2 == lk);
    foreach (mq[i]) if (mq[i].rd == lk) hit = 1'b1;
    chk("LookupHit", LookupHit, hit);

    e.we1 = 1'b0; e.wr1 = '0; e.wd1 = '0;
    e.we2 = 1'b0; e.wr2 = '0; e.wd2 = '0;
    sz = mq.size();
    if (!rr && sz >= 2) begin
      e.we1 = 1'b1;
      if (mq[0].rd == mq[1].rd) begin
        e.wr1 = mq[1].rd; e.wd1 = mq[1].data;
      end else begin
        e.wr1 = mq[0].rd; e.wd1 = mq[0].data;
        e.we2 = 1'b1; e.wr2 = mq[1].rd; e.wd2 = mq[1].data;
      end
      mq.delete(0);
      mq.delete(0);
    end else if (!rr && sz == 1) begin
      e.we1 = 1'b1; e.wr1 = mq[0].rd; e.wd1 = mq[0].data;
      mq.delete(0);
    end
    acc = ((DEPTH - sz) >= 2) && v0;
    if (acc) begin
      if (a0 != 5'd0) begin x.rd = a0; x.data = d0; mq.push_back(x); end
      if (v1 && a1 != 5'd0) begin x.rd = a1; x.data = d1; mq.push_back(x); end
    end
    e.cnt = mq.size();
    e.rdy = (DEPTH - mq.size()) >= 2;
    expq.push_back(e);
    lw1 = e.we1; lr1 = e.wr1; lw2 = e.we2; lr2 = e.wr2;
  endtask

  task automatic idle(input int n, input bit rr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rr, 5'd0, acc);
  endtask

  // Monitor: compares port state just after each rising edge against the next scoreboard entry.
  initial begin
    rec_t r;
    forever begin
      @(posedge Clk);
      #2;
      if (expq.size() > 0) begin
        r = expq.pop_front();
        chk("RegWrite1", RegWrite1, r.we1);
        chk("RegWrite2", RegWrite2, r.we2);
        if (r.we1) begin
          chk("WriteRegister1", WriteRegister1, r.wr1);
          chk("WriteData1", WriteData1, r.wd1);
        end
        if (r.we2) begin
          chk("WriteRegister2", WriteRegister2, r.wr2);
          chk("WriteData2", WriteData2, r.wd2);
        end
        chk("Count", Count, r.cnt);
        chk("InReady", InReady, r.rdy);
      end
    end
  end

  initial begin
    bit acc;
    int pairs, guard;
    logic [4:0] ra, rb;
    Reset_n = 1'b0;
    InValid0 = 0; InReg0 = 0; InData0 = 0;
    InValid1 = 0; InReg1 = 0; InData1 = 0;
    ReadReq = 0; LookupReg = 0;
    #12;
    chk("rst_Count", Count, 0);
    chk("rst_InReady", InReady, 1);
    chk("rst_RegWrite1", RegWrite1, 0);
    chk("rst_RegWrite2", RegWrite2, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // single push, then same-destination pair
    step(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 0, 5'd3, acc);
    idle(3, 0);
    step(1, 5'd4, 32'hA, 1, 5'd4, 32'hB, 0, 5'd4, acc);
    idle(3, 0);
    // register 0 discarded at enqueue
    step(1, 5'd0, 32'h5, 1, 5'd7, 32'h6, 0, 5'd0, acc);
    idle(3, 0);

    // reset mid-stream with five entries queued
    step(1, 5'd5, 32'h50, 1, 5'd6, 32'h60, 1, 5'd5, acc);
    step(1, 5'd8, 32'h80, 1, 5'd9, 32'h90, 1, 5'd6, acc);
    step(1, 5'd10, 32'hA0, 0, 5'd0, 32'h0, 1, 5'd9, acc);
    idle(1, 1);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("midrst_RegWrite1", RegWrite1, 0);
    chk("midrst_RegWrite2", RegWrite2, 0);
    chk("midrst_WriteRegister1", WriteRegister1, 0);
    chk("midrst_WriteData1", WriteData1, 0);
    chk("midrst_WriteRegister2", WriteRegister2, 0);
    chk("midrst_WriteData2", WriteData2, 0);
    chk("midrst_Count", Count, 0);
    mq.delete();
    lw1 = 1'b0; lw2 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    chk("postrst_Count", Count, 0);
    chk("postrst_InReady", InReady, 1);

    // fill under a held read window; the fifth pair must be refused
    for (int i = 0; i < 5; i++)
      step(1, 5'(2*i+1), $urandom, 1, 5'(2*i+2), $urandom, 1, (i == 0) ? 5'd20 : 5'd1, acc);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd8, acc);
    idle(6, 0);

    // 20 distinct-destination pairs with ReadReq toggling every 3 cycles
    pairs = 0;
    guard = 0;
    while (pairs < 20 && guard < 500) begin
      ra = 5'($urandom_range(1, 31));
      rb = 5'((ra % 31) + 1);
      step(1, ra, $urandom, 1, rb, $urandom, ((guard / 3) % 2) == 1, 5'($urandom_range(0, 31)), acc);
      if (acc) pairs++;
      guard++;
    end
    idle(6, 0);

    // random traffic on few registers to provoke coalescing and zero drops
    for (int i = 0; i < 300; i++) begin
      bit v0, v1;
      v0 = ($urandom % 4) != 0;
      v1 = v0 && ($urandom % 2 == 1);
      step(v0, 5'($urandom_range(0, 3)), $urandom, v1, 5'($urandom_range(0, 3)), $urandom,
           ($urandom % 4) == 0, 5'($urandom_range(0, 4)), acc);
    end
    idle(10, 0);

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(posedge Clk);
      guard++;
    end
    #3;
    chk("scoreboard_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
